m_router_2_if_rx: RTL and testbench

- Receive-side network interface: accepts 69-bit flits from the router, buffers them, and checks destination against local_id.
- Unpacks each packet into a header handshake plus a stream of 32-bit words for the PE.
- Returns one credit to the router per freed buffer slot.
- Counterpart of the send-side IF-to-router packetizer; sits inside node between router output port and PE.

---
 rtl/noc_pkg.sv | 41 ++++
 rtl/rx_flit_fifo.sv | 79 +++++++
 rtl/m_router_2_if_rx.sv | 197 +++++++++++++++++++
 tb/tb_m_router_2_if_rx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Flit format shared by the send-side and receive-side network interfaces.
//   [68:67] flit type
//   HEAD / HEAD_TAIL : [66:59] src, [58:51] dst, [50:45] seq_len, [44:39] id
//   BODY / TAIL      : [63:0] payload, low 32-bit word carried first
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int FLIT_W     = 69;
    localparam int WORD_W     = 32;
    localparam int NODE_W     = 8;
    localparam int SEQ_W      = 6;
    localparam int ID_FIELD_W = 6;

    localparam int TYPE_MSB    = 68;
    localparam int TYPE_LSB    = 67;
    localparam int HEAD_MSB    = 66;
    localparam int HEAD_LSB    = 39;
    localparam int PAYLOAD_MSB = 63;

    typedef enum logic [1:0] {
        FLIT_HEAD      = 2'b00,
        FLIT_BODY      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

    // Field order matches the flit bit order, so [66:39] casts directly.
    typedef struct packed {
        logic [NODE_W-1:0]     src;
        logic [NODE_W-1:0]     dst;
        logic [SEQ_W-1:0]      seq_len;
        logic [ID_FIELD_W-1:0] id;
    } head_t;

    function automatic logic is_head(input flit_type_e t);
        return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/rx_flit_fifo.sv
// -----------------------------------------------------------------------------
// rx_flit_fifo
// DEPTH-entry synchronous flit FIFO. A push while full is accepted only when a
// pop happens in the same cycle. Every successful pop raises credit for one
// cycle on the following cycle.
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write request and data
//   pop, dout : read request and front entry
//   empty, full
//   credit    : one-cycle pulse, one slot was freed last cycle
// -----------------------------------------------------------------------------
module rx_flit_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FLIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             credit
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             credit_q, credit_d;
    logic             push_ok, pop_ok;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (PTR_W+1)'(DEPTH));
    assign dout   = mem_q[rd_ptr_q];
    assign credit = credit_q;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        // DEPTH is a power of two, so the pointers wrap naturally.
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        credit_d = pop_ok;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; empty/full come from
    // the reset counter, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/m_router_2_if_rx.sv
// -----------------------------------------------------------------------------
// m_router_2_if_rx
// Receive-side network interface between a router output port and the PE.
// Buffers incoming flits, filters on destination, presents the header as a
// req/ack handshake and streams the payload as 32-bit words (valid/ready).
//   clk, rst        : clock, synchronous active-high reset
//   local_id        : this node's address
//   i_flit(_valid)  : flit from router
//   o_credit_valid  : one pulse per freed buffer slot
//   o_req_rx/i_ack_rx, o_src, o_id, o_seq_len : header handshake
//   o_data, o_data_valid, i_data_ready        : payload word stream
//   o_drop          : pulse, packet for another node discarded
//   o_err           : sticky protocol/overflow error
// -----------------------------------------------------------------------------
module m_router_2_if_rx
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       local_id,
    input  logic [FLIT_W-1:0]     i_flit,
    input  logic                  i_flit_valid,
    output logic                  o_credit_valid,
    output logic                  o_req_rx,
    input  logic                  i_ack_rx,
    output logic [ID_W-1:0]       o_src,
    output logic [ID_FIELD_W-1:0] o_id,
    output logic [SEQ_W-1:0]      o_seq_len,
    output logic [WORD_W-1:0]     o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic                  o_drop,
    output logic                  o_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_DROP
    } rx_state_e;

    rx_state_e             state_q, state_d;
    logic [SEQ_W-1:0]      cnt_q, cnt_d, cnt_dec;
    logic [ID_W-1:0]       src_q, src_d;
    logic [ID_FIELD_W-1:0] id_q, id_d;
    logic [SEQ_W-1:0]      seq_len_q, seq_len_d;
    logic                  err_q, err_d;
    logic                  drop_q, drop_d;

    logic [FLIT_W-1:0]     fifo_dout;
    logic                  fifo_empty, fifo_full, fifo_pop;
    flit_type_e            front_type;
    head_t                 front_head;
    logic                  front_is_data, front_is_head;
    logic                  data_valid;
    logic [WORD_W-1:0]     data_word;

    rx_flit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (i_flit_valid),
        .din    (i_flit),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .credit (o_credit_valid)
    );

    assign front_type    = flit_type_e'(fifo_dout[TYPE_MSB:TYPE_LSB]);
    assign front_head    = head_t'(fifo_dout[HEAD_MSB:HEAD_LSB]);
    assign front_is_head = !fifo_empty && is_head(front_type);
    assign front_is_data = !fifo_empty && !is_head(front_type);
    assign cnt_dec       = cnt_q - SEQ_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        id_d       = id_q;
        seq_len_d  = seq_len_q;
        err_d      = err_q;
        drop_d     = 1'b0;
        fifo_pop   = 1'b0;
        data_valid = 1'b0;
        data_word  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (!front_is_head) begin
                        err_d = 1'b1;  // data flit without a header
                    end else if (front_head.dst == local_id) begin
                        src_d     = front_head.src;
                        id_d      = front_head.id;
                        seq_len_d = front_head.seq_len;
                        state_d   = ST_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = (front_type == FLIT_HEAD_TAIL) ? ST_IDLE : ST_DROP;
                    end
                end
            end

            ST_REQ: begin
                if (i_ack_rx) begin
                    cnt_d   = seq_len_q;
                    state_d = (seq_len_q == '0) ? ST_IDLE : ST_DATA_LO;
                end
            end

            ST_DATA_LO, ST_DATA_HI: begin
                if (front_is_head) begin
                    // Packet truncated by a new header: abort, keep the header.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (front_is_data) begin
                    data_valid = 1'b1;
                    data_word  = (state_q == ST_DATA_LO) ? fifo_dout[WORD_W-1:0]
                                                         : fifo_dout[PAYLOAD_MSB:WORD_W];
                    if (i_data_ready) begin
                        cnt_d = cnt_dec;
                        if (cnt_dec == '0) begin
                            fifo_pop = 1'b1;
                            state_d  = ST_IDLE;
                        end else if (state_q == ST_DATA_LO) begin
                            state_d = ST_DATA_HI;
                        end else begin
                            fifo_pop = 1'b1;
                            if (front_type == FLIT_TAIL) begin
                                err_d   = 1'b1;  // packet shorter than seq_len
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_DATA_LO;
                            end
                        end
                    end
                end
            end

            ST_DROP: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (front_type == FLIT_TAIL) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Overflow: push while full with no pop this cycle loses the flit.
        if (i_flit_valid && fifo_full && !fifo_pop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            src_q     <= '0;
            id_q      <= '0;
            seq_len_q <= '0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            id_q      <= id_d;
            seq_len_q <= seq_len_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    assign o_req_rx     = (state_q == ST_REQ);
    assign o_src        = src_q;
    assign o_id         = id_q;
    assign o_seq_len    = seq_len_q;
    assign o_data       = data_word;
    assign o_data_valid = data_valid;
    assign o_drop       = drop_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_m_router_2_if_rx.sv
// -----------------------------------------------------------------------------
// tb_m_router_2_if_rx
// Directed bench for the receive-side network interface.
// -----------------------------------------------------------------------------
module tb_m_router_2_if_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  local_id;
    logic [68:0] i_flit;
    logic        i_flit_valid;
    logic        o_credit_valid;
    logic        o_req_rx;
    logic        i_ack_rx = 1'b0;
    logic [7:0]  o_src;
    logic [5:0]  o_id;
    logic [5:0]  o_seq_len;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        i_data_ready = 1'b1;
    logic        o_drop;
    logic        o_err;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    m_router_2_if_rx #(.DEPTH(4), .ID_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .local_id       (local_id),
        .i_flit         (i_flit),
        .i_flit_valid   (i_flit_valid),
        .o_credit_valid (o_credit_valid),
        .o_req_rx       (o_req_rx),
        .i_ack_rx       (i_ack_rx),
        .o_src          (o_src),
        .o_id           (o_id),
        .o_seq_len      (o_seq_len),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .i_data_ready   (i_data_ready),
        .o_drop         (o_drop),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- PE model: ack / ready policy ----------------
    logic auto_ack    = 1'b1;
    logic ready_level = 1'b1;
    logic ready_tog   = 1'b0;

    always begin
        @(posedge clk);
        #1;
        i_ack_rx     = auto_ack && o_req_rx;
        i_data_ready = ready_tog ? !i_data_ready : ready_level;
    end

    // ---------------- Monitor (samples on the falling edge) ----------------
    int          cyc = 0;
    int          n_credit, n_drop;
    logic [19:0] hdr_q[$];
    int          hdr_cyc_q[$];
    logic [31:0] word_q[$];
    int          word_cyc_q[$];
    logic        hold_pending = 1'b0;
    logic [31:0] hold_word;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (o_credit_valid) n_credit++;
            if (o_drop) n_drop++;
            if (o_req_rx && i_ack_rx) begin
                hdr_q.push_back({o_src, o_id, o_seq_len});
                hdr_cyc_q.push_back(cyc);
            end
            if (hold_pending) begin
                check("hold_valid", o_data_valid, 1'b1);
                check("hold_data", o_data, hold_word);
            end
            hold_pending = o_data_valid && !i_data_ready;
            hold_word    = o_data;
            if (o_data_valid && i_data_ready) begin
                word_q.push_back(o_data);
                word_cyc_q.push_back(cyc);
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_flit(input logic [68:0] f);
        i_flit       = f;
        i_flit_valid = 1'b1;
        step();
        i_flit_valid = 1'b0;
    endtask

    function automatic logic [68:0] mk_head(input logic [1:0] t, input logic [7:0] src,
                                            input logic [7:0] dst, input logic [5:0] seq,
                                            input logic [5:0] id);
        return {t, src, dst, seq, id, 39'h0};
    endfunction

    function automatic logic [68:0] mk_data(input logic [1:0] t, input logic [63:0] p);
        return {t, 3'b000, p};
    endfunction

    task automatic clear_stats();
        n_credit = 0;
        n_drop   = 0;
        hdr_q.delete();
        hdr_cyc_q.delete();
        word_q.delete();
        word_cyc_q.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic send_pkt3();
        send_flit(mk_head(T_HEAD, 8'h02, 8'h05, 6'd3, 6'd1));
        send_flit(mk_data(T_BODY, 64'h2222_2222_1111_1111));
        send_flit(mk_data(T_TAIL, 64'hDEAD_BEEF_3333_3333));
    endtask

    task automatic check_words3(input string tag);
        check({tag, "_nwords"}, word_q.size(), 3);
        if (word_q.size() == 3) begin
            check({tag, "_w0"}, word_q[0], 32'h1111_1111);
            check({tag, "_w1"}, word_q[1], 32'h2222_2222);
            check({tag, "_w2"}, word_q[2], 32'h3333_3333);
        end
        check({tag, "_credits"}, n_credit, 3);
        check({tag, "_nhdr"}, hdr_q.size(), 1);
    endtask

    int credit_snap;

    initial begin
        rst          = 1'b1;
        local_id     = 8'h05;
        i_flit       = '0;
        i_flit_valid = 1'b0;
        clear_stats();
        idle(3);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_outs", {o_req_rx, o_data_valid, o_credit_valid, o_drop, o_err,
                           o_src, o_id, o_seq_len}, 64'h0);
        check("rst_data", o_data, 32'h0);
        step();

        // 1: HEAD_TAIL, seq_len 0, header latency t+2
        clear_stats();
        send_flit(mk_head(T_HT, 8'h02, 8'h05, 6'd0, 6'd3));
        @(negedge clk);
        check("t1_req_t1", o_req_rx, 1'b0);
        @(negedge clk);
        check("t1_req_t2", o_req_rx, 1'b1);
        check("t1_src", o_src, 8'h02);
        check("t1_id", o_id, 6'd3);
        check("t1_seq", o_seq_len, 6'd0);
        check("t1_credit", o_credit_valid, 1'b1);
        @(negedge clk);
        check("t1_req_done", o_req_rx, 1'b0);
        idle(8);
        check("t1_credits", n_credit, 1);
        check("t1_nwords", word_q.size(), 0);
        check("t1_nhdr", hdr_q.size(), 1);

        // 2: 3-word packet, ready always high
        clear_stats();
        send_pkt3();
        idle(12);
        check_words3("t2");
        if (word_q.size() == 3 && hdr_cyc_q.size() == 1) begin
            check("t2_ack_lat", word_cyc_q[0] - hdr_cyc_q[0], 1);
            check("t2_thru", word_cyc_q[2] - word_cyc_q[0], 2);
        end

        // 3: same packet with ready toggling
        clear_stats();
        ready_tog = 1'b1;
        send_pkt3();
        idle(16);
        ready_tog = 1'b0;
        step();
        check_words3("t3");

        // 4: packet for another node dropped, next packet delivered
        clear_stats();
        send_flit(mk_head(T_HEAD, 8'h03, 8'h09, 6'd4, 6'd2));
        send_flit(mk_data(T_BODY, 64'h5555_5555_4444_4444));
        send_flit(mk_data(T_TAIL, 64'h7777_7777_6666_6666));
        send_flit(mk_head(T_HEAD, 8'h04, 8'h05, 6'd2, 6'd7));
        send_flit(mk_data(T_TAIL, 64'hBBBB_BBBB_AAAA_AAAA));
        idle(12);
        check("t4_drops", n_drop, 1);
        check("t4_credits", n_credit, 5);
        check("t4_nhdr", hdr_q.size(), 1);
        if (hdr_q.size() == 1) check("t4_hdr", hdr_q[0], {8'h04, 6'd7, 6'd2});
        check("t4_nwords", word_q.size(), 2);
        if (word_q.size() == 2) begin
            check("t4_w0", word_q[0], 32'hAAAA_AAAA);
            check("t4_w1", word_q[1], 32'hBBBB_BBBB);
        end
        check("t4_err", o_err, 1'b0);

        // 5: overflow while the header is not acknowledged
        clear_stats();
        auto_ack = 1'b0;
        send_flit(mk_head(T_HEAD, 8'h06, 8'h05, 6'd8, 6'd5));
        for (int k = 0; k < 4; k++) begin
            send_flit(mk_data((k == 3) ? T_TAIL : T_BODY,
                              {32'hA000_0000 + 32'(2*k+1), 32'hA000_0000 + 32'(2*k)}));
        end
        send_flit(mk_head(T_HT, 8'h07, 8'h05, 6'd0, 6'd9));
        @(negedge clk);
        check("t5_err", o_err, 1'b1);
        step();
        auto_ack = 1'b1;
        idle(20);
        check("t5_nhdr", hdr_q.size(), 1);
        check("t5_nwords", word_q.size(), 8);
        if (word_q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("t5_w%0d", k), word_q[k], 32'hA000_0000 + 32'(k));
            end
        end
        check("t5_credits", n_credit, 5);
        check("t5_err_sticky", o_err, 1'b1);

        // 6: stray BODY, then reset mid-packet
        reset_dut();
        @(negedge clk);
        check("t6_err_clr", o_err, 1'b0);
        step();
        clear_stats();
        send_flit(mk_data(T_BODY, 64'h0123_4567_89AB_CDEF));
        idle(3);
        check("t6_err", o_err, 1'b1);
        check("t6_credits", n_credit, 1);
        check("t6_nhdr", hdr_q.size(), 0);
        check("t6_nwords", word_q.size(), 0);

        ready_level = 1'b0;
        step();
        send_flit(mk_head(T_HEAD, 8'h02, 8'h05, 6'd4, 6'd1));
        send_flit(mk_data(T_BODY, 64'hCCCC_CCCC_9999_9999));
        idle(4);
        @(negedge clk);
        check("t6_stall_valid", o_data_valid, 1'b1);
        check("t6_stall_data", o_data, 32'h9999_9999);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("t6_rst_outs", {o_req_rx, o_data_valid, o_credit_valid, o_drop, o_err,
                              o_src, o_id, o_seq_len}, 64'h0);
        check("t6_rst_data", o_data, 32'h0);
        credit_snap = n_credit;
        step();
        rst         = 1'b0;
        ready_level = 1'b1;
        idle(10);
        @(negedge clk);
        check("t6_no_credit", n_credit, credit_snap);
        check("t6_idle_valid", o_data_valid, 1'b0);
        check("t6_idle_req", o_req_rx, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
